// File: rtl/lt24_pkg.sv
// Shared ILI9341 opcodes, colour words, controller state encoding and bus-word helpers
// for the LT24 graphic manager.
package lt24_pkg;

    localparam logic [15:0] CMD_SLPOUT   = 16'h0011;
    localparam logic [15:0] CMD_PIXFMT   = 16'h003A;
    localparam logic [15:0] CMD_MADCTL   = 16'h0036;
    localparam logic [15:0] CMD_DISPON   = 16'h0029;
    localparam logic [15:0] CMD_CASET    = 16'h002A;
    localparam logic [15:0] CMD_PASET    = 16'h002B;
    localparam logic [15:0] CMD_RAMWR    = 16'h002C;
    localparam logic [15:0] PIXFMT_16BPP = 16'h0055;
    localparam logic [15:0] COLOR_WHITE  = 16'hFFFF;
    localparam logic [15:0] COLOR_BLACK  = 16'h0000;

    typedef enum logic [3:0] {
        ST_RST_LOW  = 4'd0,
        ST_RST_WAIT = 4'd1,
        ST_SLP_CMD  = 4'd2,
        ST_SLP_WAIT = 4'd3,
        ST_CFG      = 4'd4,
        ST_CLR_WIN  = 4'd5,
        ST_CLR_FILL = 4'd6,
        ST_IDLE     = 4'd7,
        ST_PX       = 4'd8
    } lt24_state_e;

    // One 8080 bus transfer: rs=0 command, rs=1 data.
    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } bus_word_t;

    function automatic bus_word_t cmd_word(input logic [15:0] code);
        return {1'b0, code};
    endfunction

    function automatic bus_word_t dat_word(input logic [15:0] value);
        return {1'b1, value};
    endfunction

    // Window coordinates are sent one byte per word, upper byte of the word zero.
    function automatic logic [15:0] hi_byte(input logic [15:0] value);
        return {8'h00, value[15:8]};
    endfunction

    function automatic logic [15:0] lo_byte(input logic [15:0] value);
        return {8'h00, value[7:0]};
    endfunction

endpackage

// File: rtl/lt24_bus_writer.sv
// Single 8080 bus write engine: cs_n low from the first cycle, wr_n low then high
// for programmable cycle counts; rs/data held stable for the whole transfer.
module lt24_bus_writer #(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rs_in,
    input  logic [15:0] data_in,
    output logic        done,
    output logic        idle,
    output logic        cs_n,
    output logic        wr_n,
    output logic        rs,
    output logic [15:0] data
);

    localparam logic [15:0] LOW_LAST  = 16'(WR_LOW_CYC - 1);
    localparam logic [15:0] HIGH_LAST = 16'(WR_HIGH_CYC - 1);

    logic        active_r;
    logic        high_phase_r;
    logic [15:0] cnt_r;

    assign done = active_r && high_phase_r && (cnt_r == HIGH_LAST);
    assign idle = !active_r;

    // Transfer sequencer; a new start is taken on the last high cycle so writes chain seamlessly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r     <= 1'b0;
            high_phase_r <= 1'b0;
            cnt_r        <= 16'd0;
            cs_n         <= 1'b1;
            wr_n         <= 1'b1;
            rs           <= 1'b1;
            data         <= 16'h0000;
        end else if (start && (!active_r || done)) begin
            active_r     <= 1'b1;
            high_phase_r <= 1'b0;
            cnt_r        <= 16'd0;
            cs_n         <= 1'b0;
            wr_n         <= 1'b0;
            rs           <= rs_in;
            data         <= data_in;
        end else if (active_r && !high_phase_r) begin
            if (cnt_r == LOW_LAST) begin
                wr_n         <= 1'b1;
                high_phase_r <= 1'b1;
                cnt_r        <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end else if (active_r) begin
            if (cnt_r == HIGH_LAST) begin
                active_r <= 1'b0;
                cs_n     <= 1'b1;
                cnt_r    <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: rtl/lt24_graphic_manager.sv
// LT24 panel controller: power-up/init sequence, optional black clear, then one
// single-pixel window + RAM write per accepted write_pixel request.
module lt24_graphic_manager
    import lt24_pkg::*;
#(
    parameter int          H_RES          = 320,
    parameter int          V_RES          = 240,
    parameter int          WR_LOW_CYC     = 2,
    parameter int          WR_HIGH_CYC    = 2,
    parameter int          RST_LOW_CYC    = 500,
    parameter int          RST_WAIT_CYC   = 6000000,
    parameter int          SLEEP_WAIT_CYC = 6000000,
    parameter logic [15:0] MADCTL_VAL     = 16'h0028,
    parameter int          CLEAR_ON_INIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_pixel,
    input  logic [8:0]  pixel_col,
    input  logic [7:0]  pixel_row,
    input  logic        bw_pixel_color,
    output logic        initialized,
    output logic        busy,
    output logic        overrun,
    output logic        lcd_reset_n,
    output logic        lcd_on,
    output logic        lcd_cs_n,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic        lcd_rs,
    output logic [15:0] lcd_data
);

    localparam logic [15:0] H_MAX      = 16'(H_RES - 1);
    localparam logic [15:0] V_MAX      = 16'(V_RES - 1);
    localparam logic [9:0]  H_LIM      = 10'(H_RES);
    localparam logic [8:0]  V_LIM      = 9'(V_RES);
    localparam logic [16:0] FILL_WORDS = 17'(H_RES * V_RES);
    localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYC - 1);
    localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYC - 1);
    localparam logic [31:0] SLEEP_LAST    = 32'(SLEEP_WAIT_CYC - 1);

    lt24_state_e state_r, next_state_s;
    logic [3:0]  step_r;
    logic [31:0] wait_cnt_r;
    logic [16:0] fill_cnt_r;
    logic [8:0]  px_col_r;
    logic [7:0]  px_row_r;
    logic        px_color_r;

    bus_word_t   cur_word_s;
    logic [3:0]  seq_len_s;
    logic        seq_done_s;
    logic        accept_s;
    logic        wr_start_s;
    logic        wr_done_s;
    logic        wr_idle_s;
    logic        wr_ready_s;
    logic [15:0] col16_s;
    logic [15:0] row16_s;

    assign lcd_rd_n   = 1'b1;
    assign wr_ready_s = wr_idle_s || wr_done_s;
    assign col16_s    = {7'd0, px_col_r};
    assign row16_s    = {8'd0, px_row_r};
    assign seq_done_s = (step_r == seq_len_s) && wr_ready_s;
    assign accept_s   = write_pixel && ({1'b0, pixel_col} < H_LIM) && ({1'b0, pixel_row} < V_LIM);

    lt24_bus_writer #(
        .WR_LOW_CYC  (WR_LOW_CYC),
        .WR_HIGH_CYC (WR_HIGH_CYC)
    ) u_writer (
        .clk     (clk),
        .reset   (reset),
        .start   (wr_start_s),
        .rs_in   (cur_word_s.rs),
        .data_in (cur_word_s.data),
        .done    (wr_done_s),
        .idle    (wr_idle_s),
        .cs_n    (lcd_cs_n),
        .wr_n    (lcd_wr_n),
        .rs      (lcd_rs),
        .data    (lcd_data)
    );

    // Word table: what each sequencing state sends at each step.
    always_comb begin
        cur_word_s = cmd_word(16'h0000);
        seq_len_s  = 4'd0;
        case (state_r)
            ST_SLP_CMD: begin
                seq_len_s  = 4'd1;
                cur_word_s = cmd_word(CMD_SLPOUT);
            end
            ST_CFG: begin
                seq_len_s = 4'd5;
                case (step_r)
                    4'd0:    cur_word_s = cmd_word(CMD_PIXFMT);
                    4'd1:    cur_word_s = dat_word(PIXFMT_16BPP);
                    4'd2:    cur_word_s = cmd_word(CMD_MADCTL);
                    4'd3:    cur_word_s = dat_word(MADCTL_VAL);
                    default: cur_word_s = cmd_word(CMD_DISPON);
                endcase
            end
            ST_CLR_WIN: begin
                seq_len_s = 4'd11;
                case (step_r)
                    4'd0:       cur_word_s = cmd_word(CMD_CASET);
                    4'd1, 4'd2: cur_word_s = dat_word(16'h0000);
                    4'd3:       cur_word_s = dat_word(hi_byte(H_MAX));
                    4'd4:       cur_word_s = dat_word(lo_byte(H_MAX));
                    4'd5:       cur_word_s = cmd_word(CMD_PASET);
                    4'd6, 4'd7: cur_word_s = dat_word(16'h0000);
                    4'd8:       cur_word_s = dat_word(hi_byte(V_MAX));
                    4'd9:       cur_word_s = dat_word(lo_byte(V_MAX));
                    default:    cur_word_s = cmd_word(CMD_RAMWR);
                endcase
            end
            ST_CLR_FILL: cur_word_s = dat_word(COLOR_BLACK);
            ST_PX: begin
                seq_len_s = 4'd12;
                case (step_r)
                    4'd0:       cur_word_s = cmd_word(CMD_CASET);
                    4'd1, 4'd3: cur_word_s = dat_word(hi_byte(col16_s));
                    4'd2, 4'd4: cur_word_s = dat_word(lo_byte(col16_s));
                    4'd5:       cur_word_s = cmd_word(CMD_PASET);
                    4'd6, 4'd8: cur_word_s = dat_word(hi_byte(row16_s));
                    4'd7, 4'd9: cur_word_s = dat_word(lo_byte(row16_s));
                    4'd10:      cur_word_s = cmd_word(CMD_RAMWR);
                    default:    cur_word_s = dat_word(px_color_r ? COLOR_WHITE : COLOR_BLACK);
                endcase
            end
            default: cur_word_s = cmd_word(16'h0000);
        endcase
    end

    // Next-state and bus start decode.
    always_comb begin
        next_state_s = state_r;
        wr_start_s   = 1'b0;
        case (state_r)
            ST_RST_LOW: begin
                if (wait_cnt_r == RST_LOW_LAST) next_state_s = ST_RST_WAIT;
                else                            next_state_s = ST_RST_LOW;
            end
            ST_RST_WAIT: begin
                if (wait_cnt_r == RST_WAIT_LAST) next_state_s = ST_SLP_CMD;
                else                             next_state_s = ST_RST_WAIT;
            end
            ST_SLP_CMD: begin
                wr_start_s = wr_ready_s && (step_r < seq_len_s);
                if (seq_done_s) next_state_s = ST_SLP_WAIT;
                else            next_state_s = ST_SLP_CMD;
            end
            ST_SLP_WAIT: begin
                if (wait_cnt_r == SLEEP_LAST) next_state_s = ST_CFG;
                else                          next_state_s = ST_SLP_WAIT;
            end
            ST_CFG: begin
                wr_start_s = wr_ready_s && (step_r < seq_len_s);
                if (seq_done_s) next_state_s = (CLEAR_ON_INIT != 0) ? ST_CLR_WIN : ST_IDLE;
                else            next_state_s = ST_CFG;
            end
            ST_CLR_WIN: begin
                wr_start_s = wr_ready_s && (step_r < seq_len_s);
                if (seq_done_s) next_state_s = ST_CLR_FILL;
                else            next_state_s = ST_CLR_WIN;
            end
            ST_CLR_FILL: begin
                wr_start_s = wr_ready_s && (fill_cnt_r != 17'd0);
                if (wr_ready_s && (fill_cnt_r == 17'd0)) next_state_s = ST_IDLE;
                else                                     next_state_s = ST_CLR_FILL;
            end
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_PX;
                else          next_state_s = ST_IDLE;
            end
            ST_PX: begin
                wr_start_s = wr_ready_s && (step_r < seq_len_s);
                if (seq_done_s) next_state_s = ST_IDLE;
                else            next_state_s = ST_PX;
            end
            default: next_state_s = ST_RST_LOW;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_RST_LOW;
        else       state_r <= next_state_s;
    end

    // Counters, request capture and registered status/panel-control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_r      <= 4'd0;
            wait_cnt_r  <= 32'd0;
            fill_cnt_r  <= 17'd0;
            px_col_r    <= 9'd0;
            px_row_r    <= 8'd0;
            px_color_r  <= 1'b0;
            lcd_reset_n <= 1'b0;
            lcd_on      <= 1'b0;
            initialized <= 1'b0;
            busy        <= 1'b1;
            overrun     <= 1'b0;
        end else begin
            if (next_state_s != state_r) begin
                step_r     <= 4'd0;
                wait_cnt_r <= 32'd0;
            end else begin
                if (wr_start_s) step_r <= step_r + 4'd1;
                if ((state_r == ST_RST_LOW) || (state_r == ST_RST_WAIT) || (state_r == ST_SLP_WAIT))
                    wait_cnt_r <= wait_cnt_r + 32'd1;
            end

            // Clear length uses a down-counter loaded as the window setup completes.
            if ((state_r == ST_CLR_WIN) && (next_state_s == ST_CLR_FILL))
                fill_cnt_r <= FILL_WORDS;
            else if ((state_r == ST_CLR_FILL) && wr_start_s)
                fill_cnt_r <= fill_cnt_r - 17'd1;

            if ((state_r == ST_RST_LOW) && (next_state_s == ST_RST_WAIT)) begin
                lcd_reset_n <= 1'b1;
                lcd_on      <= 1'b1;
            end

            if ((state_r != ST_IDLE) && (next_state_s == ST_IDLE)) begin
                initialized <= 1'b1;
                busy        <= 1'b0;
            end else if ((state_r == ST_IDLE) && (next_state_s == ST_PX)) begin
                busy       <= 1'b1;
                px_col_r   <= pixel_col;
                px_row_r   <= pixel_row;
                px_color_r <= bw_pixel_color;
            end

            if (write_pixel && (busy || !initialized)) overrun <= 1'b1;
        end
    end

endmodule
